// File: rtl/axi_stream_strip_header.sv
// rtl/axi_stream_strip_header.sv - strips an S-byte header from the first beat and MSB-realigns the payload (optional header port: STRIP_HEADER_OUT_EN)
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    ready_strip
`ifdef STRIP_HEADER_OUT_EN
    ,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic                    ready_header
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FIRST  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_FLUSH  = 2'd3;

    localparam logic [BYTE_CNT_WD:0] CNT_N = (BYTE_CNT_WD+1)'(DATA_BYTE_WD);

    // MSB-contiguous keep with cnt ones
    function automatic logic [DATA_BYTE_WD-1:0] keep_from_cnt(input logic [BYTE_CNT_WD:0] cnt);
        logic [DATA_BYTE_WD-1:0] k;
        k = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            k[DATA_BYTE_WD-1-i] = (i < int'(cnt));
        end
        return k;
    endfunction

    function automatic logic [DATA_WD-1:0] mask_from_keep(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[8*i +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    logic [1:0]              r_state;
    logic [BYTE_CNT_WD-1:0]  r_s;
    logic [DATA_WD-1:0]      r_resid;
    logic [BYTE_CNT_WD:0]    r_flush_cnt;
    logic                    r_valid_out;
    logic [DATA_WD-1:0]      r_data_out;
    logic [DATA_BYTE_WD-1:0] r_keep_out;
    logic                    r_last_out;

    logic                    w_out_free;
    logic                    w_ready_in;
    logic                    w_ready_strip;
    logic                    w_in_hs;
    logic                    w_strip_hs;
    logic [BYTE_CNT_WD:0]    w_vcnt;
    logic [BYTE_CNT_WD:0]    w_s_ext;
    logic                    w_v_gt_s;
    logic [BYTE_CNT_WD:0]    w_comb_cnt;
    logic [BYTE_CNT_WD:0]    w_tail_cnt;
    logic [31:0]             w_shl;
    logic [31:0]             w_shr;
    logic [DATA_WD-1:0]      w_resid_next;
    logic [DATA_WD-1:0]      w_comb_data;
    logic [DATA_BYTE_WD-1:0] w_comb_keep;
    logic [DATA_BYTE_WD-1:0] w_flush_keep;
    logic [DATA_BYTE_WD-1:0] w_full_keep;

    assign w_out_free = !r_valid_out || ready_out;

`ifdef STRIP_HEADER_OUT_EN
    logic                    r_valid_header;
    logic [DATA_WD-1:0]      r_data_header;
    logic [DATA_BYTE_WD-1:0] r_keep_header;

    assign w_ready_in = ((r_state == S_FIRST) && w_out_free && !r_valid_header) ||
                        ((r_state == S_STREAM) && w_out_free);
`else
    assign w_ready_in = ((r_state == S_FIRST) || (r_state == S_STREAM)) && w_out_free;
`endif

    // A new command waits until the previous packet's last beat has left
    assign w_ready_strip = (r_state == S_IDLE) && !r_valid_out;
    assign w_in_hs       = valid_in && w_ready_in;
    assign w_strip_hs    = valid_strip && w_ready_strip;

    assign w_vcnt       = (BYTE_CNT_WD+1)'($countones(keep_in));
    assign w_s_ext      = {1'b0, r_s};
    assign w_v_gt_s     = w_vcnt > w_s_ext;
    assign w_comb_cnt   = CNT_N - w_s_ext + w_vcnt;
    assign w_tail_cnt   = w_vcnt - w_s_ext;
    assign w_shl        = 32'(r_s) << 3;
    assign w_shr        = (32'(DATA_BYTE_WD) - 32'(r_s)) << 3;
    assign w_resid_next = data_in << w_shl;
    assign w_comb_data  = r_resid | (data_in >> w_shr);
    assign w_comb_keep  = keep_from_cnt(w_comb_cnt);
    assign w_flush_keep = keep_from_cnt(r_flush_cnt);
    assign w_full_keep  = {DATA_BYTE_WD{1'b1}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_s         <= '0;
            r_resid     <= '0;
            r_flush_cnt <= '0;
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
            r_keep_out  <= '0;
            r_last_out  <= 1'b0;
        end else begin
            if (r_valid_out && ready_out) begin
                r_valid_out <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_strip_hs) begin
                        r_s     <= byte_strip_cnt;
                        r_state <= S_FIRST;
                    end
                end
                S_FIRST: begin
                    if (w_in_hs) begin
                        r_resid <= w_resid_next;
                        if (!last_in) begin
                            r_state <= S_STREAM;
                        end else if (w_v_gt_s) begin
                            r_flush_cnt <= w_tail_cnt;
                            r_state     <= S_FLUSH;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_STREAM: begin
                    if (w_in_hs) begin
                        r_valid_out <= 1'b1;
                        if (last_in && !w_v_gt_s) begin
                            r_data_out <= w_comb_data & mask_from_keep(w_comb_keep);
                            r_keep_out <= w_comb_keep;
                            r_last_out <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_data_out <= w_comb_data;
                            r_keep_out <= w_full_keep;
                            r_last_out <= 1'b0;
                            r_resid    <= w_resid_next;
                            if (last_in) begin
                                r_flush_cnt <= w_tail_cnt;
                                r_state     <= S_FLUSH;
                            end
                        end
                    end
                end
                default: begin
                    if (w_out_free) begin
                        r_valid_out <= 1'b1;
                        r_data_out  <= r_resid & mask_from_keep(w_flush_keep);
                        r_keep_out  <= w_flush_keep;
                        r_last_out  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef STRIP_HEADER_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_header <= 1'b0;
            r_data_header  <= '0;
            r_keep_header  <= '0;
        end else if ((r_state == S_FIRST) && w_in_hs && (r_s != '0)) begin
            r_valid_header <= 1'b1;
            r_data_header  <= data_in & mask_from_keep(keep_from_cnt(w_s_ext));
            r_keep_header  <= keep_from_cnt(w_s_ext);
        end else if (r_valid_header && ready_header) begin
            r_valid_header <= 1'b0;
        end
    end

    assign valid_header = r_valid_header;
    assign data_header  = r_data_header;
    assign keep_header  = r_keep_header;
`endif

    assign ready_in    = w_ready_in;
    assign ready_strip = w_ready_strip;
    assign valid_out   = r_valid_out;
    assign data_out    = r_data_out;
    assign keep_out    = r_keep_out;
    assign last_out    = r_last_out;

endmodule

// File: doc/axi_stream_strip_header.md
# axi_stream_strip_header

Receive-side counterpart of the header-insertion path. It accepts an AXI-Stream packet whose first beat begins with a header of `byte_strip_cnt` bytes and removes those bytes. The remaining payload is re-aligned so the first payload byte lands in the MSB byte lane. It sits at the ingress of the packet path, ahead of payload consumers.

## Interface
- `DATA_WD`, 32, stream data width in bits; multiple of 8, at least 16
- `DATA_BYTE_WD`, `DATA_WD/8`, bytes per beat
- `BYTE_CNT_WD`, `$clog2(DATA_BYTE_WD)`, width of the strip count
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `valid_in` input 1: input beat valid
- `data_in` input `DATA_WD`: input data; byte 0 is `[DATA_WD-1 -: 8]`
- `keep_in` input `DATA_BYTE_WD`: byte enables, MSB-contiguous (e.g. 1111/1110/1100/1000)
- `last_in` input 1: last beat of the packet
- `ready_in` output 1: input beat accepted
- `valid_out` output 1: output beat valid
- `data_out` output `DATA_WD`: re-aligned payload
- `keep_out` output `DATA_BYTE_WD`: MSB-contiguous byte enables
- `last_out` output 1: last payload beat
- `ready_out` input 1: downstream ready
- `valid_strip` input 1: strip command valid
- `byte_strip_cnt` input `BYTE_CNT_WD`: S, header bytes to strip, 0..`DATA_BYTE_WD`-1
- `ready_strip` output 1: strip command accepted
- `valid_header`, `data_header`, `keep_header`, `ready_header`: header port; present only with `STRIP_HEADER_OUT_EN`

## Operation
- **States**
  - IDLE: `ready_strip`=1 and `ready_in`=0. A `valid_strip`&`ready_strip` handshake latches S and moves to FIRST.
  - FIRST: accepts beat 0. Bytes S..N-1 go to the residual register. Next state is STREAM if `last_in`=0, otherwise FLUSH or IDLE as below.
  - STREAM: accepts beat k+1. It emits residual bytes (N-S) concatenated with bytes 0..S-1 of beat k+1. Bytes S..N-1 of beat k+1 become the new residual.
  - FLUSH: emits the residual alone, with `last_out`=1, then returns to IDLE.
- **Last-beat rule** (V = valid bytes of the last input beat)
  - STREAM, V<=S: the combined beat is the last one; `keep_out` has (N-S)+V MSB ones; go to IDLE.
  - STREAM, V>S: the combined beat has a full keep; FLUSH follows with V-S MSB ones.
  - FIRST with `last_in`, V>S: FLUSH follows with V-S bytes.
  - FIRST with `last_in`, V<=S: the packet is fully stripped; no output beat; go to IDLE.
- S=0 uses the same rules. The output equals the input, delayed by one beat.
- `ready_in` = state∈{FIRST,STREAM} & (!`valid_out` | `ready_out`). With the macro, FIRST additionally requires !`valid_header`.
- Invalid byte lanes of `data_out` are driven 0.
- `valid_in` asserted while in IDLE stalls; it is never dropped.

## Timing
- Reset values:
  - `valid_out`, `data_out`, `keep_out`, `last_out` = 0
  - `ready_in` = 0
  - `ready_strip` = 1 (IDLE)
  - header outputs = 0
- All stream outputs are registered.
- `valid_out` rises the cycle after the beat-k+1 handshake. For FLUSH it rises the cycle after the previous output handshake.
- While `valid_out`&!`ready_out`, `data_out`, `keep_out` and `last_out` hold stable.
- Full throughput: one beat per cycle while `ready_out`=1.
- Each packet adds at most one extra (FLUSH) cycle.
- The next `ready_strip` is asserted the cycle after the last output handshake, or the cycle after the last input handshake for a fully stripped packet.
- Reset mid-packet: residual is discarded, state returns to IDLE, outputs go to reset values immediately.

## Configuration
- `STRIP_HEADER_OUT_EN` defined:
  - In FIRST, bytes 0..S-1 are loaded MSB-aligned into `data_header`, with `keep_header` set to S MSB ones and `valid_header`=1.
  - The header is held until `ready_header`.
  - When S=0, no header beat is produced.
- `STRIP_HEADER_OUT_EN` undefined: the header ports are absent and header bytes are discarded.

## Test plan (DATA_WD=32)
- S=1; input A0A1A2A3, B0B1B2B3, C0C1C2C3 (keep 1111, last on the third beat) -> output A1A2A3B0, B1B2B3C0, then C1C2C300 with keep 1110 and last.
- S=2; last beat C0C10000 with keep 1100 -> exactly two output beats, A2A3B0B1 and B2B3C0C1; the second has keep 1111 and last; no FLUSH beat.
- Single-beat packet A0A1A200, keep 1110, S=3 -> no `valid_out`; `ready_strip`=1 on the next cycle. With the macro: header A0A1A200, keep 1110.
- S=0, two beats with last keep 1000 -> output is identical data; second beat has keep 1000 and last.
- S=3, 16-beat incrementing payload, `ready_out` randomly low for 0–15 cycles -> concatenated output bytes equal the input bytes minus the first 3, with no loss or duplication; outputs stable while stalled.
- `rst_n` pulsed low mid-packet -> all outputs reach reset values asynchronously. A following packet with S=1 matches the first scenario.
